// File: rtl/addsub_bcd_display.sv
// Add / signed-magnitude subtract of two unsigned operands, sequential double-dabble
// to BCD, and a multiplexed active-low seven-segment driver. Optional: LEADING_ZERO_BLANK_EN.
module addsub_bcd_display #(
  parameter int WIDTH        = 8,
  parameter int DIGITS       = 4,
  parameter int REFRESH_BITS = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              sub,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [WIDTH:0]    result,
  output logic              neg,
  output logic [DIGITS-1:0] Anode,
  output logic [6:0]        LED_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SEL_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(WIDTH + 2);

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     sh_q, sh_d;
  logic [WIDTH:0]     mag_q, mag_d;
  logic               neg_pend_q, neg_pend_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic [WIDTH:0]     result_q, result_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [REFRESH_BITS-1:0] ref_q, ref_d;

  logic [WIDTH:0]     a_ext, b_ext, mag_in;
  logic               a_lt_b, neg_in;
  logic [BCD_W-1:0]   bcd_adj;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Operand magnitude is one bit wider than the inputs so A+B never wraps
  always_comb begin
    a_ext  = {1'b0, A};
    b_ext  = {1'b0, B};
    a_lt_b = (A < B);
    neg_in = sub & a_lt_b;
    if (!sub)
      mag_in = a_ext + b_ext;
    else if (a_lt_b)
      mag_in = b_ext - a_ext;
    else
      mag_in = a_ext - b_ext;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    mag_d      = mag_q;
    neg_pend_d = neg_pend_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    disp_d     = disp_q;
    result_d   = result_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    ref_d      = ref_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          mag_d      = mag_in;
          sh_d       = mag_in;
          neg_pend_d = neg_in;
          ovf_pend_d = 1'b0;
          cnt_d      = CNT_W'(WIDTH + 1);
          bcd_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // A bit leaving the top nibble means the value needs more digits than we have
        bcd_d = {bcd_adj[BCD_W-2:0], sh_q[WIDTH]};
        if (bcd_adj[BCD_W-1])
          ovf_pend_d = 1'b1;
        sh_d  = {sh_q[WIDTH-1:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = LOAD;
      end
      LOAD: begin
        disp_d   = bcd_q;
        result_d = mag_q;
        neg_d    = neg_pend_q;
        ovf_d    = ovf_pend_q | (neg_pend_q && (bcd_q[BCD_W-1 -: 4] != 4'd0));
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      mag_q      <= '0;
      neg_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      disp_q     <= '0;
      result_q   <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      ref_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      mag_q      <= mag_d;
      neg_pend_q <= neg_pend_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      disp_q     <= disp_d;
      result_q   <= result_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      ref_q      <= ref_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign ovf    = ovf_q;
  assign neg    = neg_q;
  assign result = result_q;

  logic [SEL_W-1:0] sel;
  logic [3:0]       cur_digit;
  logic             cur_blank;
  logic             sel_valid;
`ifdef LEADING_ZERO_BLANK_EN
  logic             zero_run;
`endif

  assign sel = ref_q[REFRESH_BITS-1 -: SEL_W];

  // Glyph priority: overflow dashes, then sign digit, then blanking, then numeral
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    sel_valid = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp_q[4*i +: 4] == 4'd0);
      if ((SEL_W'(i) == sel) && (i != 0))
        cur_blank = zero_run;
    end
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (SEL_W'(i) == sel) begin
        cur_digit = disp_q[4*i +: 4];
        sel_valid = 1'b1;
      end
    end
    if (!sel_valid) begin
      Anode   = '1;
      LED_out = SEG_BLANK;
    end else begin
      Anode = ~(DIGITS'(1) << sel);
      if (ovf_q)
        LED_out = SEG_DASH;
      else if (neg_q && (sel == SEL_W'(DIGITS - 1)))
        LED_out = SEG_DASH;
      else if (cur_blank)
        LED_out = SEG_BLANK;
      else
        LED_out = seg7(cur_digit);
    end
  end

endmodule

// File: tb/tb_addsub_bcd_display.sv
// Scoreboard bench for addsub_bcd_display: 8-bit, 16-bit and 3-digit instances.
module tb_addsub_bcd_display;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G9 = 7'b0000100;
  localparam logic [6:0] GM = 7'b1111110;
  localparam logic [6:0] GB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] GZ = GB;
`else
  localparam logic [6:0] GZ = G0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]  a_A, a_B;
  logic        a_sub, a_start, a_busy, a_done, a_ovf, a_neg;
  logic [8:0]  a_res;
  logic [3:0]  a_an;
  logic [6:0]  a_led;

  logic [15:0] b_A, b_B;
  logic        b_sub, b_start, b_busy, b_done, b_ovf, b_neg;
  logic [16:0] b_res;
  logic [3:0]  b_an;
  logic [6:0]  b_led;

  logic [7:0]  c_A, c_B;
  logic        c_sub, c_start, c_busy, c_done, c_ovf, c_neg;
  logic [8:0]  c_res;
  logic [2:0]  c_an;
  logic [6:0]  c_led;

  addsub_bcd_display #(.WIDTH(8), .DIGITS(4), .REFRESH_BITS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .A(a_A), .B(a_B), .sub(a_sub), .start(a_start),
    .busy(a_busy), .done(a_done), .ovf(a_ovf), .result(a_res), .neg(a_neg),
    .Anode(a_an), .LED_out(a_led));

  addsub_bcd_display #(.WIDTH(16), .DIGITS(4), .REFRESH_BITS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .A(b_A), .B(b_B), .sub(b_sub), .start(b_start),
    .busy(b_busy), .done(b_done), .ovf(b_ovf), .result(b_res), .neg(b_neg),
    .Anode(b_an), .LED_out(b_led));

  addsub_bcd_display #(.WIDTH(8), .DIGITS(3), .REFRESH_BITS(4)) u_c (
    .clk(clk), .rst_n(rst_n), .A(c_A), .B(c_B), .sub(c_sub), .start(c_start),
    .busy(c_busy), .done(c_done), .ovf(c_ovf), .result(c_res), .neg(c_neg),
    .Anode(c_an), .LED_out(c_led));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycles since reset release, used to predict the digit being scanned
  logic [3:0] rc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rc <= '0;
    else        rc <= rc + 1'b1;
  end

  typedef struct {
    logic [16:0] res;
    logic        neg;
    logic        ovf;
    longint      due;
    logic        chk;
    logic [27:0] g;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int checks = 0;
  int failures = 0;
  bit mon_a_busy = 1'b0;
  bit mon_b_busy = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] gl(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic scan_check(input int which, input logic [27:0] g, input string nm);
    int s;
    logic [3:0] an;
    logic [6:0] led;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      s   = int'(rc[3:2]);
      an  = (which == 0) ? a_an : b_an;
      led = (which == 0) ? a_led : b_led;
      chk({nm, "_anode"}, an, 4'hF ^ (4'h1 << s));
      chk({nm, "_seg"}, led, g[s*7 +: 7]);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n && a_done) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_done actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_result", a_res, ea.res);
        chk("a_neg", a_neg, ea.neg);
        chk("a_ovf", a_ovf, ea.ovf);
        chk("a_done_cycle", cyc, ea.due);
        chk("a_busy_at_done", a_busy, 0);
        if (ea.chk) begin
          mon_a_busy = 1'b1;
          scan_check(0, ea.g, "a_disp");
          mon_a_busy = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && b_done) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_done actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_result", b_res, eb.res);
        chk("b_neg", b_neg, eb.neg);
        chk("b_ovf", b_ovf, eb.ovf);
        chk("b_done_cycle", cyc, eb.due);
        if (eb.chk) begin
          mon_b_busy = 1'b1;
          scan_check(1, eb.g, "b_disp");
          mon_b_busy = 1'b0;
        end
      end
    end
  end

  task automatic issue_a(input logic [7:0] a, b, input logic s, input logic [16:0] r,
                         input logic n, o, c, input logic [27:0] g);
    exp_t e;
    @(negedge clk);
    a_A = a; a_B = b; a_sub = s; a_start = 1'b1;
    e.res = r; e.neg = n; e.ovf = o; e.due = cyc + 11; e.chk = c; e.g = g;
    qa.push_back(e);
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic issue_b(input logic [15:0] a, b, input logic s, input logic [16:0] r,
                         input logic n, o, c, input logic [27:0] g);
    exp_t e;
    @(negedge clk);
    b_A = a; b_B = b; b_sub = s; b_start = 1'b1;
    e.res = r; e.neg = n; e.ovf = o; e.due = cyc + 19; e.chk = c; e.g = g;
    qb.push_back(e);
    @(negedge clk);
    b_start = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int n = 0;
    while (n < 300 && ((which == 0) ? (qa.size() != 0 || mon_a_busy)
                                    : (qb.size() != 0 || mon_b_busy))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_%0d actual=timeout required=done within 300 cycles", which);
    end
  endtask

  initial begin
    int n;
    int s;
    a_A = '0; a_B = '0; a_sub = 1'b0; a_start = 1'b0;
    b_A = '0; b_B = '0; b_sub = 1'b0; b_start = 1'b0;
    c_A = '0; c_B = '0; c_sub = 1'b0; c_start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_result", a_res, 0);
    chk("rst_neg", a_neg, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_anode", a_an, 4'b1110);
    chk("rst_seg", a_led, G0);
    chk("rst_c_anode", c_an, 3'b110);
    rst_n = 1'b1;

    issue_a(8'd200, 8'd255, 1'b0, 17'd455, 1'b0, 1'b0, 1'b1, gl(GZ, G4, G5, G5));
    wait_idle(0);
    issue_a(8'd5, 8'd9, 1'b1, 17'd4, 1'b1, 1'b0, 1'b1, gl(GM, GZ, GZ, G4));
    wait_idle(0);
    issue_a(8'd9, 8'd5, 1'b1, 17'd4, 1'b0, 1'b0, 1'b0, '0);
    wait_idle(0);
    issue_a(8'd0, 8'd255, 1'b1, 17'd255, 1'b1, 1'b0, 1'b0, '0);
    wait_idle(0);
    issue_a(8'd0, 8'd0, 1'b0, 17'd0, 1'b0, 1'b0, 1'b1, gl(GZ, GZ, GZ, G0));
    wait_idle(0);

    // Second start 3 edges in is ignored; a start in the done cycle is accepted
    @(negedge clk);
    a_A = 8'd100; a_B = 8'd23; a_sub = 1'b0; a_start = 1'b1;
    qa.push_back('{res: 17'd123, neg: 1'b0, ovf: 1'b0, due: cyc + 11, chk: 1'b0, g: '0});
    @(negedge clk); a_start = 1'b0; a_A = 8'd1; a_B = 8'd1;
    @(negedge clk);
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0; a_A = 8'd2; a_B = 8'd2;
    n = 0;
    while (!a_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("a_first_done_seen", a_done, 1);
    a_A = 8'd7; a_B = 8'd3; a_sub = 1'b1; a_start = 1'b1;
    qa.push_back('{res: 17'd4, neg: 1'b0, ovf: 1'b0, due: cyc + 11, chk: 1'b1,
                   g: gl(GZ, GZ, GZ, G4)});
    @(negedge clk); a_start = 1'b0;
    wait_idle(0);

    issue_b(16'd65535, 16'd1, 1'b0, 17'd65536, 1'b0, 1'b1, 1'b1, gl(GM, GM, GM, GM));
    wait_idle(1);
    issue_b(16'd9999, 16'd0, 1'b0, 17'd9999, 1'b0, 1'b0, 1'b1, gl(G9, G9, G9, G9));
    wait_idle(1);
    issue_b(16'd0, 16'd1000, 1'b1, 17'd1000, 1'b1, 1'b1, 1'b1, gl(GM, GM, GM, GM));
    wait_idle(1);
    issue_b(16'd0, 16'd999, 1'b1, 17'd999, 1'b1, 1'b0, 1'b1, gl(GM, G9, G9, G9));
    wait_idle(1);

    // Reset after edge 5 of a conversion: no done, display back to "0"
    @(negedge clk);
    a_A = 8'd50; a_B = 8'd50; a_sub = 1'b0; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", a_busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_done", a_done, 0);
    chk("mid_rst_result", a_res, 0);
    chk("mid_rst_anode", a_an, 4'b1110);
    chk("mid_rst_seg", a_led, G0);
    @(negedge clk);
    rst_n = 1'b1;
    scan_check(0, gl(GZ, GZ, GZ, G0), "a_after_rst");

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      s = int'(rc[3:2]);
      chk("c_anode", c_an, (s == 3) ? 3'b111 : (3'b111 ^ (3'b001 << s)));
      chk("c_seg", c_led, (s == 3) ? GB : ((s == 0) ? G0 : GZ));
    end

    repeat (12) @(negedge clk);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
